// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory wait states and a stall watchdog.
// Optional `define ILLEGAL_OP_TRAP_EN routes unknown opcodes through TRAP to HALT instead of treating them as NOPs.
module mips_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCwrite,
  output logic       PCwriteCOND,
  output logic [1:0] PCsource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRwrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       MemTimeout,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [CW-1:0] r_wait;
  logic          r_is_sw;
  logic          w_mem_state;
  logic          w_stall;
  logic          w_timeout;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
  assign w_stall     = w_mem_state && !MemReady;
  assign w_timeout   = w_stall && (r_wait == CW'(MEM_TIMEOUT));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADDR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADDR:  w_next = r_is_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (MemReady) w_next = S_FETCH;
      S_EXEC:     w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_ADDIEX:   w_next = S_ADDIWB;
      S_ADDIWB:   w_next = S_FETCH;
      S_TRAP:     w_next = S_HALT;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
    // MemReady on the expiry cycle already kept w_timeout low, so the normal transition wins
    if (w_timeout) w_next = S_HALT;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_is_sw <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_stall && !w_timeout) r_wait <= r_wait + CW'(1);
      else                       r_wait <= '0;
      if (r_state == S_DECODE) r_is_sw <= (Opcode == OP_SW);
    end
  end

  always_comb begin
    PCwrite     = 1'b0;
    PCwriteCOND = 1'b0;
    PCsource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRwrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    case (r_state)
      S_FETCH: begin
        // Reset parks the FSM in FETCH; mask the Mealy strobes so no write fires while it is held
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRwrite = MemReady && !Reset;
        PCwrite = MemReady && !Reset;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCwriteCOND = 1'b1;
        PCsource    = 2'b01;
      end
      S_JUMP: begin
        PCwrite  = 1'b1;
        PCsource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:   RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign MemTimeout = w_timeout && !Reset;
  assign State      = r_state;

endmodule
